// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit seven-segment scan controller with blanking and digit masking
module display_scan_ctrl #(
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic       SEL0,
    output logic       SEL1,
    output logic [3:0] dig_n,
    output logic       frame_start
);

    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  dig_n_q, dig_n_d;
    logic        frame_q, frame_d;

    logic [1:0]  mask_low;
    logic [1:0]  mask_next;
    logic [3:0]  lit_pattern;

    // Lowest set bit of the mask; the frame always begins on this digit.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_set = 2'(i);
        end
    endfunction

    // First set bit strictly after cur, wrapping 3->0; stays on cur when it is the only one.
    function automatic logic [1:0] next_set(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] cand;
        next_set = cur;
        for (int k = 3; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (m[cand]) next_set = cand;
        end
    endfunction

    assign mask_low    = lowest_set(digit_mask);
    assign mask_next   = next_set(idx_q, digit_mask);
    // The active digit lights only while its mask bit stays set.
    assign lit_pattern = digit_mask[idx_q] ? ~(4'b0001 << idx_q) : 4'b1111;

    // Next-state logic: slot sequencing, digit advance and registered output values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        dig_n_d = 4'b1111;
        frame_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = 2'd0;
                cnt_d = '0;
                if (en && (digit_mask != 4'b0000)) begin
                    state_d = S_BLANK;
                    idx_d   = mask_low;
                    sel_d   = mask_low;
                    frame_d = 1'b1;
                end
            end
            S_BLANK: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_ON;
                    dig_n_d = lit_pattern;
                end
            end
            S_ON: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (digit_mask != 4'b0000) begin
                        state_d = S_BLANK;
                        idx_d   = mask_next;
                        sel_d   = mask_next;
                        frame_d = (mask_next == mask_low);
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = 2'd0;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    dig_n_d = lit_pattern;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        // Disable abandons any partial slot; select is left alone so it never moves under a lit digit.
        if (!en) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            sel_d   = sel_q;
            dig_n_d = 4'b1111;
            frame_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            dig_n_q <= 4'b1111;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dig_n_q <= dig_n_d;
            frame_q <= frame_d;
        end
    end

    assign SEL0        = sel_q[1];
    assign SEL1        = sel_q[0];
    assign dig_n       = dig_n_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic       SEL0, SEL1;
    logic [3:0] dig_n;
    logic       frame_start;

    int total = 0;
    int bad   = 0;

    display_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(mask),
        .SEL0(SEL0), .SEL1(SEL1), .dig_n(dig_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference model: scan position within the current slot and the digit it belongs to.
    bit         m_active = 1'b0;
    int         m_pos = 0;
    int         m_dig = 0;
    logic [1:0] m_sel = 2'b00;
    logic       m_frame = 1'b0;
    logic [3:0] m_dign = 4'hF;

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int after(input int d, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(d + k) % 4]) return (d + k) % 4;
        return d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_pos = 0; m_dig = 0; m_sel = 2'b00; m_frame = 0; m_dign = 4'hF;
        end else if (!en) begin
            m_active = 0; m_frame = 0; m_dign = 4'hF;
        end else if (!m_active) begin
            m_frame = 0; m_dign = 4'hF;
            if (mask != 0) begin
                m_active = 1; m_pos = 0; m_dig = lowest(mask);
                m_sel = 2'(m_dig); m_frame = 1;
            end
        end else if (m_pos == SLOT - 1) begin
            m_dign = 4'hF;
            if (mask == 0) begin
                m_active = 0; m_frame = 0;
            end else begin
                m_dig = after(m_dig, mask); m_pos = 0;
                m_sel = 2'(m_dig); m_frame = (m_dig == lowest(mask));
            end
        end else begin
            m_pos++;
            m_frame = 0;
            m_dign = (m_pos >= BLANK && mask[m_dig]) ? ~(4'b0001 << m_dig) : 4'hF;
        end
    end

    // Invariants: select moves only while all digits are dark; never more than one digit lit.
    logic [1:0] prev_sel = 2'b00;
    always @(posedge clk) begin
        #1;
        total++;
        if ({SEL0, SEL1} !== prev_sel && dig_n !== 4'hF) begin
            bad++;
            $display("FAIL sel_glitch: sel %b->%b with dig_n=%b, required dig_n=1111", prev_sel, {SEL0, SEL1}, dig_n);
        end
        total++;
        if ($countones(~dig_n) > 1) begin
            bad++;
            $display("FAIL one_hot: dig_n=%b has %0d zeros, required at most 1", dig_n, $countones(~dig_n));
        end
        prev_sel = {SEL0, SEL1};
    end

    task automatic test_reset();
        @(posedge clk); #1;
        total++;
        if ({SEL0, SEL1, dig_n, frame_start} !== 7'b00_1111_0) begin
            bad++;
            $display("FAIL reset: sel=%b dig_n=%b fs=%b, required sel=00 dig_n=1111 fs=0", {SEL0, SEL1}, dig_n, frame_start);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if ({SEL0, SEL1, dig_n, frame_start} !== {m_sel, m_dign, m_frame}) begin
                bad++;
                $display("FAIL idle: sel=%b dig_n=%b fs=%b, required sel=%b dig_n=%b fs=%b", {SEL0, SEL1}, dig_n, frame_start, m_sel, m_dign, m_frame);
            end
        end
    endtask

    task automatic test_pattern(input logic [3:0] mk, input string name);
        int period, last_fs, n_on;
        period = SLOT * $countones(mk);
        last_fs = 0;
        n_on = 0;
        @(negedge clk); en = 1'b0;
        @(negedge clk); mask = mk; en = 1'b1;
        for (int c = 1; c <= 2 * period + 3; c++) begin
            @(posedge clk); #1;
            total++;
            if ({SEL0, SEL1, dig_n, frame_start} !== {m_sel, m_dign, m_frame}) begin
                bad++;
                $display("FAIL %s cyc%0d: sel=%b dig_n=%b fs=%b, required sel=%b dig_n=%b fs=%b", name, c, {SEL0, SEL1}, dig_n, frame_start, m_sel, m_dign, m_frame);
            end
            if (c <= 2 * period && dig_n !== 4'hF) n_on++;
            if (frame_start === 1'b1) begin
                total++;
                if ((last_fs == 0 && c != 1) || (last_fs != 0 && c - last_fs != period)) begin
                    bad++;
                    $display("FAIL %s frame_gap: frame at cyc%0d after cyc%0d, required period %0d", name, c, last_fs, period);
                end
                last_fs = c;
            end
        end
        total++;
        if (n_on != 2 * $countones(mk) * (SLOT - BLANK)) begin
            bad++;
            $display("FAIL %s on_time: %0d lit cycles, required %0d", name, n_on, 2 * $countones(mk) * (SLOT - BLANK));
        end
    endtask

    task automatic test_clear_mid_on();
        int seen_fs;
        seen_fs = 0;
        @(negedge clk); en = 1'b0;
        @(negedge clk); mask = 4'b1111; en = 1'b1;
        repeat (4) @(negedge clk);
        mask = 4'b1110;
        for (int c = 0; c < SLOT + 4; c++) begin
            @(posedge clk); #1;
            total++;
            if ({SEL0, SEL1, dig_n, frame_start} !== {m_sel, m_dign, m_frame}) begin
                bad++;
                $display("FAIL clr_bit cyc%0d: sel=%b dig_n=%b fs=%b, required sel=%b dig_n=%b fs=%b", c, {SEL0, SEL1}, dig_n, frame_start, m_sel, m_dign, m_frame);
            end
            if (c == 0) begin
                total++;
                if (dig_n !== 4'hF) begin
                    bad++;
                    $display("FAIL clr_dark: dig_n=%b, required 1111", dig_n);
                end
            end
            if (c == 4) begin
                total++;
                if ({SEL0, SEL1} !== 2'b01) begin
                    bad++;
                    $display("FAIL clr_next: sel=%b, required 01", {SEL0, SEL1});
                end
            end
        end
        @(negedge clk); mask = 4'b0000;
        for (int c = 0; c < 2 * SLOT; c++) begin
            @(posedge clk); #1;
            if (frame_start === 1'b1) seen_fs++;
            total++;
            if ({SEL0, SEL1, dig_n, frame_start} !== {m_sel, m_dign, m_frame}) begin
                bad++;
                $display("FAIL clr_all cyc%0d: sel=%b dig_n=%b fs=%b, required sel=%b dig_n=%b fs=%b", c, {SEL0, SEL1}, dig_n, frame_start, m_sel, m_dign, m_frame);
            end
        end
        total++;
        if (seen_fs != 0 || dig_n !== 4'hF) begin
            bad++;
            $display("FAIL clr_idle: frames=%0d dig_n=%b, required frames=0 dig_n=1111", seen_fs, dig_n);
        end
    endtask

    task automatic test_drop_and_reset();
        @(negedge clk); mask = 4'b1111; en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        total++;
        if (dig_n !== 4'hF || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL en_drop: dig_n=%b fs=%b, required dig_n=1111 fs=0", dig_n, frame_start);
        end
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({SEL0, SEL1, dig_n, frame_start} !== 7'b00_1111_1) begin
            bad++;
            $display("FAIL re_enable: sel=%b dig_n=%b fs=%b, required sel=00 dig_n=1111 fs=1", {SEL0, SEL1}, dig_n, frame_start);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({SEL0, SEL1, dig_n, frame_start} !== 7'b00_1111_0) begin
            bad++;
            $display("FAIL async_reset: sel=%b dig_n=%b fs=%b, required sel=00 dig_n=1111 fs=0", {SEL0, SEL1}, dig_n, frame_start);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({SEL0, SEL1, dig_n, frame_start} !== 7'b00_1111_1) begin
            bad++;
            $display("FAIL post_reset: sel=%b dig_n=%b fs=%b, required sel=00 dig_n=1111 fs=1", {SEL0, SEL1}, dig_n, frame_start);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) en = ~en;
            if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({SEL0, SEL1, dig_n, frame_start} !== {m_sel, m_dign, m_frame}) begin
                bad++;
                $display("FAIL random cyc%0d: sel=%b dig_n=%b fs=%b, required sel=%b dig_n=%b fs=%b", c, {SEL0, SEL1}, dig_n, frame_start, m_sel, m_dign, m_frame);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pattern(4'b1111, "mask1111");
        test_pattern(4'b1010, "mask1010");
        test_pattern(4'b0100, "mask0100");
        test_clear_mid_on();
        test_drop_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
